pci_chk_par: RTL and testbench
==============================

// Module: pci_chk_par
// PURPOSE
//  Receive-side PCI parity checker; consumes the PAR line the transmit-side generator drives.
//  Checks address phases and accepted data phases (write target / read master).
//  Drives internal PERR#/SERR# requests and their enables one stage before the pad drivers.
//  Keeps sticky status bits and an error counter for the config-space block.
// PARAMETERS
//  CNT_W     8   width of saturating data-parity error counter
//  CHK_ADDR  1   1 = check address parity and generate SERR; 0 = address phases ignored
// PORTS
//  clk          in   1      PCI clock; single clock domain
//  rst          in   1      synchronous, active-high reset
//  adi          in   32     AD bus as sampled this clock
//  cbei         in   4      C/BE# bus as sampled this clock
//  pari         in   1      PAR as sampled; covers adi/cbei of previous clock
//  addr_ph      in   1      this clock is an address phase (FRAME# first asserted)
//  data_ph      in   1      this clock is an accepted data phase (IRDY# & TRDY#) with us receiving
//  perr_resp_en in   1      command reg bit 6 (parity error response)
//  serr_en      in   1      command reg bit 8 (SERR# enable)
//  sts_clr      in   2      write-1-clear: [0] sts_dpe, [1] sts_sse
//  cnt_clr      in   1      clears err_cnt
//  perr_o       out  1      request PERR# low (active-high internally)
//  perr_oe      out  1      PERR# output enable
//  serr_o       out  1      request SERR# low; also its open-drain enable
//  sts_dpe      out  1      sticky: detected parity error (data or address)
//  sts_sse      out  1      sticky: signaled system error
//  err_cnt      out  CNT_W  count of data-parity errors, saturating
// BEHAVIOUR
//  Reset: every output and internal stage = 0; pending checks dropped; mid-cycle reset aborts all.
//  Parity: even over {adi,cbei}, 36 bits. Error = (^{adi,cbei}) != pari, evaluated one clock later.
//  Pipeline, phase at clock N:
//   N   : register p36 = ^{adi,cbei}, vld_d = data_ph, vld_a = addr_ph & CHK_ADDR
//   N+1 : err_d = vld_d & (p36 != pari); err_a = vld_a & (p36 != pari); both registered
//   N+2 : perr_o = err_d & perr_resp_en; serr_o = err_a & perr_resp_en & serr_en
//  PERR# drive: perr_oe high at N+2 (perr_o=1) and N+3 (perr_o=0, driven-high turnaround);
//   back-to-back errors keep perr_o high on consecutive clocks; oe stays until 1 clock after the last.
//  SERR#: exactly one-clock pulse per address error; no turnaround (open drain).
//  sts_dpe set at N+2 on err_d or err_a regardless of perr_resp_en.
//  sts_sse set whenever serr_o asserts.
//  Sticky bits: set has priority over sts_clr in the same clock.
//  err_cnt: +1 per err_d at N+2; saturates at all-ones; cnt_clr and increment together -> 1.
//  addr_ph and data_ph together (protocol violation): treated as address phase only.
//  perr_resp_en/serr_en are sampled at N+2, not at the phase clock.
// STRUCTURE
//  Shared include pci_defs.vh: command-reg bit indices (PERR_RESP=6, SERR_EN=8),
//   status-reg bit indices (DPE=15, SSE=14), PCI command codes.
//  Sub-module pci_par_tree: registered 36-bit XOR reduce (clk, rst, d[35:0] -> p); it is
//   shared in form with the transmit-side generator.
//  Remainder: pipeline valid flags, compare, PERR oe extender, stickies, counter.
// TESTING
//  1 adi=32'h0000_0001 cbei=0 data_ph; pari=1 next clk -> no perr_o/oe; sts_dpe=0; err_cnt=0.
//  2 same phase, pari=0, perr_resp_en=1 -> perr_o=1 at N+2; perr_oe=1 at N+2,N+3; sts_dpe=1; err_cnt=1.
//  3 three consecutive bad data phases -> perr_o high for 3 clocks; oe high for 4; err_cnt=3.
//  4 addr_ph adi=32'hFFFF_FFFF cbei=4'h6 pari=1, serr_en=perr_resp_en=1 -> serr_o 1-clk pulse at A+2;
//    sts_sse=1; sts_dpe=1. Repeat with serr_en=0 -> no serr_o, sts_dpe=1.
//  5 CNT_W=2, 5 errors -> err_cnt=3; sts_clr=2'b01 coincident with new error -> sts_dpe stays 1.
//  6 bad data phase then rst at N+1 -> perr_o/perr_oe never assert; all outputs 0 after reset.

Source files
------------

// File: rtl/pci_chk_par_pkg.sv
// Shared definitions for the receive-side PCI parity checker.
// Config-space bit positions, PCI command codes and pipeline flag bundle.
package pci_chk_par_pkg;

   localparam int PAR_W         = 36;
   localparam int CMD_PERR_RESP = 6;
   localparam int CMD_SERR_EN   = 8;
   localparam int STS_DPE       = 15;
   localparam int STS_SSE       = 14;

   typedef enum logic [3:0] {
      CMD_INT_ACK  = 4'h0,
      CMD_SPECIAL  = 4'h1,
      CMD_IO_RD    = 4'h2,
      CMD_IO_WR    = 4'h3,
      CMD_MEM_RD   = 4'h6,
      CMD_MEM_WR   = 4'h7,
      CMD_CFG_RD   = 4'hA,
      CMD_CFG_WR   = 4'hB,
      CMD_MEM_RDM  = 4'hC,
      CMD_DUAL_AD  = 4'hD,
      CMD_MEM_RDL  = 4'hE,
      CMD_MEM_WRI  = 4'hF
   } pci_cmd_e;

   // One flag per phase kind travelling down the check pipeline.
   typedef struct packed {
      logic dat;
      logic adr;
   } chk_flag_t;

endpackage

// File: rtl/pci_par_tree.sv
// Registered 36-bit even-parity reduce over {AD, C/BE#}.
// Same form as the tree used by the transmit-side PAR generator.
module pci_par_tree
   import pci_chk_par_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [PAR_W-1:0] d,
   output logic             p
);

   logic p_q;
   logic p_d;

   assign p_d = ^d;

   always_ff @(posedge clk) begin
      if (rst) p_q <= 1'b0;
      else     p_q <= p_d;
   end

   assign p = p_q;

endmodule

// File: rtl/pci_chk_par.sv
// Receive-side PCI parity checker: PERR#/SERR# requests, sticky
// status bits and a saturating data-parity error counter.
module pci_chk_par
   import pci_chk_par_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter bit CHK_ADDR = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      adi,
   input  logic [3:0]       cbei,
   input  logic             pari,
   input  logic             addr_ph,
   input  logic             data_ph,
   input  logic             perr_resp_en,
   input  logic             serr_en,
   input  logic [1:0]       sts_clr,
   input  logic             cnt_clr,
   output logic             perr_o,
   output logic             perr_oe,
   output logic             serr_o,
   output logic             sts_dpe,
   output logic             sts_sse,
   output logic [CNT_W-1:0] err_cnt
);

   logic             p36;
   logic             mis;
   chk_flag_t        vld_d, vld_q;
   chk_flag_t        err_d, err_q;
   logic             perr_dly_q;
   logic             dpe_d, dpe_q;
   logic             sse_d, sse_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   pci_par_tree u_tree (
      .clk (clk),
      .rst (rst),
      .d   ({adi, cbei}),
      .p   (p36)
   );

   // Address phase wins when both strobes are seen together.
   assign vld_d.adr = addr_ph & CHK_ADDR;
   assign vld_d.dat = data_ph & ~addr_ph;

   assign mis       = p36 ^ pari;
   assign err_d.adr = vld_q.adr & mis;
   assign err_d.dat = vld_q.dat & mis;

   assign perr_o  = err_q.dat & perr_resp_en;
   assign serr_o  = err_q.adr & perr_resp_en & serr_en;
   // Extra clock of enable drives PERR# high for turnaround.
   assign perr_oe = perr_o | perr_dly_q;

   always_comb begin
      dpe_d = dpe_q;
      sse_d = sse_q;
      cnt_d = cnt_q;
      if (sts_clr[0]) dpe_d = 1'b0;
      if (sts_clr[1]) sse_d = 1'b0;
      if (err_q.dat || err_q.adr) dpe_d = 1'b1;
      if (serr_o) sse_d = 1'b1;
      if (cnt_clr) begin
         cnt_d = err_q.dat ? CNT_W'(1) : '0;
      end else if (err_q.dat && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         err_q      <= '0;
         perr_dly_q <= 1'b0;
         dpe_q      <= 1'b0;
         sse_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         vld_q      <= vld_d;
         err_q      <= err_d;
         perr_dly_q <= perr_o;
         dpe_q      <= dpe_d;
         sse_q      <= sse_d;
         cnt_q      <= cnt_d;
      end
   end

   assign sts_dpe = dpe_q;
   assign sts_sse = sse_q;
   assign err_cnt = cnt_q;

endmodule

// File: tb/tb_pci_chk_par.sv
// Self-checking bench for pci_chk_par: directed scenarios plus random
// traffic against a per-phase history model of the parity rules.
module tb_pci_chk_par;

   typedef struct packed {
      logic        rst;
      logic [31:0] adi;
      logic [3:0]  cbe;
      logic        pari;
      logic        aph;
      logic        dph;
      logic        pre;
      logic        sen;
      logic [1:0]  clr;
      logic        cclr;
   } vec_t;

   localparam int MAXC = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adi = '0;
   logic [3:0]  cbei = '0;
   logic        pari = 1'b0;
   logic        addr_ph = 1'b0;
   logic        data_ph = 1'b0;
   logic        perr_resp_en = 1'b0;
   logic        serr_en = 1'b0;
   logic [1:0]  sts_clr = '0;
   logic        cnt_clr = 1'b0;

   logic       perr_o, perr_oe, serr_o, sts_dpe, sts_sse;
   logic [7:0] err_cnt;
   logic       perr2, oe2, serr2, dpe2, sse2;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   pci_chk_par u8 (
      .clk(clk), .rst(rst), .adi(adi), .cbei(cbei), .pari(pari),
      .addr_ph(addr_ph), .data_ph(data_ph),
      .perr_resp_en(perr_resp_en), .serr_en(serr_en),
      .sts_clr(sts_clr), .cnt_clr(cnt_clr),
      .perr_o(perr_o), .perr_oe(perr_oe), .serr_o(serr_o),
      .sts_dpe(sts_dpe), .sts_sse(sts_sse), .err_cnt(err_cnt)
   );

   pci_chk_par #(.CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .adi(adi), .cbei(cbei), .pari(pari),
      .addr_ph(addr_ph), .data_ph(data_ph),
      .perr_resp_en(perr_resp_en), .serr_en(serr_en),
      .sts_clr(sts_clr), .cnt_clr(cnt_clr),
      .perr_o(perr2), .perr_oe(oe2), .serr_o(serr2),
      .sts_dpe(dpe2), .sts_sse(sse2), .err_cnt(cnt2)
   );

   logic [19:0] obs, expv;
   assign obs = {perr_o, perr_oe, serr_o, sts_dpe, sts_sse,
                 perr2, oe2, serr2, dpe2, sse2, err_cnt, cnt2};

   vec_t h [MAXC];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;
   logic dpe_m = 0, sse_m = 0, perr_m = 0;
   int   cnt8_m = 0, cnt2_m = 0;

   function automatic logic par(input vec_t v);
      return ^{v.adi, v.cbe};
   endfunction

   // A phase at clock n is an error if it survived reset through n+1
   // and PAR seen at n+1 disagrees with the even parity of phase n.
   function automatic logic bad(input int n, input bit is_addr);
      if (n < 0) return 1'b0;
      if (h[n].rst || h[n+1].rst) return 1'b0;
      if (is_addr && !h[n].aph) return 1'b0;
      if (!is_addr && !(h[n].dph && !h[n].aph)) return 1'b0;
      return par(h[n]) != h[n+1].pari;
   endfunction

   function automatic vec_t idle(input logic p);
      vec_t v;
      v = '0;
      v.pari = p;
      v.pre = 1'b1;
      v.sen = 1'b1;
      return v;
   endfunction

   task automatic step(input vec_t v);
      logic bd, ba, ep, es, eo;
      @(posedge clk);
      #1;
      rst = v.rst; adi = v.adi; cbei = v.cbe; pari = v.pari;
      addr_ph = v.aph; data_ph = v.dph;
      perr_resp_en = v.pre; serr_en = v.sen;
      sts_clr = v.clr; cnt_clr = v.cclr;
      h[cyc] = v;
      @(negedge clk);
      bd = bad(cyc - 2, 1'b0);
      ba = bad(cyc - 2, 1'b1);
      ep = bd & v.pre;
      es = ba & v.pre & v.sen;
      eo = ep | perr_m;
      expv = {ep, eo, es, dpe_m, sse_m, ep, eo, es, dpe_m, sse_m,
              8'(cnt8_m), 2'(cnt2_m)};
      if (v.rst) begin
         perr_m = 0; dpe_m = 0; sse_m = 0; cnt8_m = 0; cnt2_m = 0;
      end else begin
         perr_m = ep;
         dpe_m = bd | ba | (dpe_m & !v.clr[0]);
         sse_m = es | (sse_m & !v.clr[1]);
         if (v.cclr) begin
            cnt8_m = bd ? 1 : 0;
            cnt2_m = bd ? 1 : 0;
         end else if (bd) begin
            cnt8_m = (cnt8_m < 255) ? cnt8_m + 1 : 255;
            cnt2_m = (cnt2_m < 3) ? cnt2_m + 1 : 3;
         end
      end
      cyc++;
   endtask

   task automatic clear_all();
      vec_t v;
      v = idle(1'b0);
      v.clr = 2'b11;
      v.cclr = 1'b1;
      step(v);
      step(idle(1'b0));
   endtask

   task automatic test_reset();
      vec_t v;
      v = idle(1'b0);
      v.rst = 1'b1;
      step(v);
      step(v);
      step(idle(1'b0));
      nvec++;
      if (obs !== expv) begin
         nerr++;
         $display("FAIL reset_model got %h exp %h", obs, expv);
      end
      nvec++;
      if (obs !== 20'h0) begin
         nerr++;
         $display("FAIL reset_zero got %h exp 0", obs);
      end
   endtask

   task automatic test_clean_data();
      vec_t s[$];
      vec_t v;
      logic hit = 1'b0;
      v = idle(1'b0); v.dph = 1'b1; v.adi = 32'h0000_0001;
      s.push_back(v);
      s.push_back(idle(1'b1));
      repeat (3) s.push_back(idle(1'b0));
      foreach (s[i]) begin
         step(s[i]);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL clean[%0d] got %h exp %h", i, obs, expv);
         end
         hit |= perr_o | perr_oe;
      end
      nvec++;
      if (hit !== 1'b0 || sts_dpe !== 1'b0 || err_cnt !== 8'd0) begin
         nerr++;
         $display("FAIL clean_final got perr %b dpe %b cnt %0d exp 0 0 0",
                  hit, sts_dpe, err_cnt);
      end
   endtask

   task automatic test_bad_data();
      vec_t s[$];
      vec_t v;
      logic [5:0] po, oe;
      v = idle(1'b0); v.dph = 1'b1; v.adi = 32'h0000_0001;
      s.push_back(v);
      s.push_back(idle(1'b0));
      repeat (4) s.push_back(idle(1'b0));
      foreach (s[i]) begin
         step(s[i]);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL bad[%0d] got %h exp %h", i, obs, expv);
         end
         po[i] = perr_o;
         oe[i] = perr_oe;
      end
      nvec++;
      if (po !== 6'b000100 || oe !== 6'b001100) begin
         nerr++;
         $display("FAIL bad_shape got perr %b oe %b exp 000100 001100",
                  po, oe);
      end
      nvec++;
      if (sts_dpe !== 1'b1 || err_cnt !== 8'd1) begin
         nerr++;
         $display("FAIL bad_sts got dpe %b cnt %0d exp 1 1",
                  sts_dpe, err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      vec_t s[$];
      vec_t v, pv;
      int np = 0, no = 0;
      clear_all();
      pv = idle(1'b0);
      for (int i = 0; i < 3; i++) begin
         v = idle(~par(pv));
         v.dph = 1'b1;
         v.adi = $urandom;
         v.cbe = 4'($urandom);
         s.push_back(v);
         pv = v;
      end
      s.push_back(idle(~par(pv)));
      repeat (4) s.push_back(idle(1'b0));
      foreach (s[i]) begin
         step(s[i]);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL b2b[%0d] got %h exp %h", i, obs, expv);
         end
         np += int'(perr_o);
         no += int'(perr_oe);
      end
      nvec++;
      if (np != 3 || no != 4 || err_cnt !== 8'd3) begin
         nerr++;
         $display("FAIL b2b_count got perr %0d oe %0d cnt %0d exp 3 4 3",
                  np, no, err_cnt);
      end
   endtask

   task automatic test_addr_serr(input logic sen);
      vec_t s[$];
      vec_t v;
      int ns = 0;
      clear_all();
      v = idle(1'b0); v.aph = 1'b1; v.adi = 32'hFFFF_FFFF; v.cbe = 4'h6;
      s.push_back(v);
      s.push_back(idle(1'b1));
      repeat (4) s.push_back(idle(1'b0));
      foreach (s[i]) begin
         s[i].sen = sen;
         step(s[i]);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL addr%0b[%0d] got %h exp %h", sen, i, obs, expv);
         end
         if (serr_o) begin
            ns++;
            if (i != 2) ns += 10;
         end
      end
      nvec++;
      if (ns != int'(sen) || sts_sse !== sen || sts_dpe !== 1'b1) begin
         nerr++;
         $display("FAIL addr%0b_sts got serr %0d sse %b dpe %b exp %0d %b 1",
                  sen, ns, sts_sse, sts_dpe, sen, sen);
      end
   endtask

   task automatic test_saturate();
      vec_t s[$];
      vec_t v, pv;
      clear_all();
      pv = idle(1'b0);
      for (int i = 0; i < 5; i++) begin
         v = idle(~par(pv));
         v.dph = 1'b1;
         v.adi = $urandom;
         s.push_back(v);
         pv = v;
      end
      s.push_back(idle(~par(pv)));
      repeat (3) s.push_back(idle(1'b0));
      v = idle(1'b0); v.dph = 1'b1; v.adi = 32'h3;
      s.push_back(v);
      s.push_back(idle(1'b1));
      v = idle(1'b0); v.clr = 2'b01;
      s.push_back(v);
      s.push_back(idle(1'b0));
      foreach (s[i]) begin
         step(s[i]);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL sat[%0d] got %h exp %h", i, obs, expv);
         end
      end
      nvec++;
      if (cnt2 !== 2'd3 || err_cnt !== 8'd6 || sts_dpe !== 1'b1) begin
         nerr++;
         $display("FAIL sat_final got cnt2 %0d cnt8 %0d dpe %b exp 3 6 1",
                  cnt2, err_cnt, sts_dpe);
      end
   endtask

   task automatic test_reset_abort();
      vec_t s[$];
      vec_t v;
      logic hit = 1'b0;
      clear_all();
      v = idle(1'b0); v.dph = 1'b1; v.adi = 32'h0000_0001;
      s.push_back(v);
      v = idle(1'b0); v.rst = 1'b1;
      s.push_back(v);
      repeat (4) s.push_back(idle(1'b0));
      foreach (s[i]) begin
         step(s[i]);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL abort[%0d] got %h exp %h", i, obs, expv);
         end
         hit |= perr_o | perr_oe;
      end
      nvec++;
      if (hit !== 1'b0 || obs !== 20'h0) begin
         nerr++;
         $display("FAIL abort_final got perr %b out %h exp 0 0", hit, obs);
      end
   endtask

   task automatic test_random();
      vec_t v, pv;
      pv = h[cyc-1];
      for (int i = 0; i < 1500; i++) begin
         v = '0;
         v.rst  = ($urandom_range(0, 59) == 0);
         v.adi  = $urandom;
         v.cbe  = 4'($urandom);
         v.aph  = ($urandom_range(0, 5) == 0);
         v.dph  = ($urandom_range(0, 1) == 0);
         v.pre  = ($urandom_range(0, 7) != 0);
         v.sen  = ($urandom_range(0, 3) != 0);
         v.clr  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
         v.cclr = ($urandom_range(0, 31) == 0);
         v.pari = par(pv) ^ ($urandom_range(0, 3) == 0);
         step(v);
         nvec++;
         if (obs !== expv) begin
            nerr++;
            $display("FAIL rand[%0d] got %h exp %h", i, obs, expv);
         end
         pv = v;
      end
   endtask

   initial begin
      test_reset();
      test_clean_data();
      test_bad_data();
      test_back_to_back();
      test_addr_serr(1'b1);
      test_addr_serr(1'b0);
      test_saturate();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
